// File: rtl/id_pkg.sv
// Shared state encodings and character constants for the identifier recognizer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package id_pkg;

   // Recognizer state: S0 idle, S1 inside the letter run, S2 inside the digit run.
   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10
   } state_t;

   localparam logic [7:0] CH_NUL = 8'h00;  // frame terminator
   localparam logic [7:0] CH_US  = 8'h5F;  // '_'
   localparam logic [7:0] CH_LA  = 8'h61;  // 'a'
   localparam logic [7:0] CH_LZ  = 8'h7A;  // 'z'
   localparam logic [7:0] CH_UA  = 8'h41;  // 'A'
   localparam logic [7:0] CH_UZ  = 8'h5A;  // 'Z'
   localparam logic [7:0] CH_D0  = 8'h30;  // '0'
   localparam logic [7:0] CH_D9  = 8'h39;  // '9'

endpackage

// File: rtl/id_step.sv
// One recognizer step: classifies a character and computes next state plus identifier completion.
// Latency: purely combinational.
// Backpressure: none; IDSCHED_UNDERSCORE_EN makes '_' count as a letter.
module id_step
   import id_pkg::*;
(
   input  state_t     state_i,
   input  logic [7:0] char_i,
   output state_t     next_state_o,
   output logic       completion_o
);

`ifdef IDSCHED_UNDERSCORE_EN
   localparam bit US_IS_LETTER = 1'b1;
`else
   localparam bit US_IS_LETTER = 1'b0;
`endif

   logic is_alpha;
   logic is_us;
   logic is_letter;
   logic is_digit;

   // Character classification; '_' joins the letter class only when enabled.
   always_comb begin
      is_alpha  = ((char_i >= CH_LA) && (char_i <= CH_LZ)) ||
                  ((char_i >= CH_UA) && (char_i <= CH_UZ));
      is_us     = (char_i == CH_US);
      is_letter = is_alpha || (US_IS_LETTER && is_us);
      is_digit  = (char_i >= CH_D0) && (char_i <= CH_D9);
   end

   // Transition: letters (re)start an identifier, digits extend one only after letters,
   // anything else (including NUL) returns to idle and closes a digit run.
   always_comb begin
      next_state_o = S0;
      completion_o = 1'b0;
      if (is_letter) begin
         next_state_o = S1;
      end else if (is_digit) begin
         next_state_o = (state_i == S0) ? S0 : S2;
      end
      if ((state_i == S2) && !is_digit) begin
         completion_o = 1'b1;
      end
   end

endmodule

// File: rtl/id_stream_sched.sv
// Round-robin shares one id_step between NUM_SRC streams with per-source context and id counts.
// Latency: one cycle from transfer to out_*; at most one character consumed per cycle.
// Backpressure: src_ready is a combinational one-hot grant; ungranted sources hold char and valid.
// Build option: IDSCHED_UNDERSCORE_EN (see id_step) classifies '_' as a letter.
module id_stream_sched
   import id_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = 2,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SRC-1:0]     src_valid,
   input  logic [8*NUM_SRC-1:0]   src_char,
   output logic [NUM_SRC-1:0]     src_ready,
   output logic                   out_valid,
   output logic [SRC_W-1:0]       out_src,
   output logic                   out_match,
   output logic                   out_frame_done,
   output logic [CNT_W-1:0]       out_count
);

   logic [SRC_W-1:0] rr_q, rr_d;
   state_t           ctx_q [NUM_SRC];
   logic [CNT_W-1:0] cnt_q [NUM_SRC];

   logic             gnt_vld;
   logic [SRC_W-1:0] gnt_idx;
   logic             xfer;
   state_t           sel_state;
   logic [7:0]       sel_char;
   logic [CNT_W-1:0] sel_cnt;
   logic [CNT_W-1:0] cnt_sum;
   logic             is_nul;
   state_t           step_next;
   logic             step_comp;

   logic             out_valid_q;
   logic [SRC_W-1:0] out_src_q;
   logic             out_match_q;
   logic             out_frame_done_q;
   logic [CNT_W-1:0] out_count_q;

   // Round-robin search from rr_q upward; scanning the ring from farthest to nearest lets
   // the nearest valid source overwrite earlier hits.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NUM_SRC;
         if (src_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = SRC_W'(idx);
         end
      end
   end

   // Grant is suppressed during reset so nothing is consumed while state is held clear.
   always_comb begin
      xfer      = gnt_vld && reset;
      src_ready = '0;
      if (xfer) begin
         src_ready[gnt_idx] = 1'b1;
      end
      rr_d = rr_q;
      if (xfer) begin
         rr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end
   end

   // Select the granted source's character and saved context for the shared step.
   always_comb begin
      sel_state = S0;
      sel_char  = '0;
      sel_cnt   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt_idx == SRC_W'(i)) begin
            sel_state = ctx_q[i];
            sel_char  = src_char[i*8 +: 8];
            sel_cnt   = cnt_q[i];
         end
      end
   end

   id_step u_step (
      .state_i      (sel_state),
      .char_i       (sel_char),
      .next_state_o (step_next),
      .completion_o (step_comp)
   );

   // Saturating count including the identifier this character may close.
   always_comb begin
      is_nul  = (sel_char == CH_NUL);
      cnt_sum = sel_cnt;
      if (step_comp && (sel_cnt != '1)) begin
         cnt_sum = sel_cnt + CNT_W'(1);
      end
   end

   // Arbiter pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   // Per-source context: only the transferring source updates; NUL starts a fresh frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            ctx_q[i] <= S0;
            cnt_q[i] <= '0;
         end
      end else if (xfer) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
               if (is_nul) begin
                  ctx_q[i] <= S0;
                  cnt_q[i] <= '0;
               end else begin
                  ctx_q[i] <= step_next;
                  cnt_q[i] <= cnt_sum;
               end
            end
         end
      end
   end

   // Registered per-character result; all fields read zero on idle cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q      <= 1'b0;
         out_src_q        <= '0;
         out_match_q      <= 1'b0;
         out_frame_done_q <= 1'b0;
         out_count_q      <= '0;
      end else begin
         out_valid_q      <= xfer;
         out_src_q        <= xfer ? gnt_idx : '0;
         out_match_q      <= xfer && (step_next == S2);
         out_frame_done_q <= xfer && is_nul;
         out_count_q      <= (xfer && is_nul) ? cnt_sum : '0;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_src        = out_src_q;
   assign out_match      = out_match_q;
   assign out_frame_done = out_frame_done_q;
   assign out_count      = out_count_q;

endmodule

// File: tb/tb_id_stream_sched.sv
// Directed bench for id_stream_sched (NUM_SRC=4, CNT_W=2 so saturation is reachable).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-derived from the character sequences.
module tb_id_stream_sched;

   localparam int NUM_SRC = 4;
   localparam int SRC_W   = 2;
   localparam int CNT_W   = 2;

   logic                 clk;
   logic                 reset;
   logic [NUM_SRC-1:0]   src_valid;
   logic [8*NUM_SRC-1:0] src_char;
   logic [NUM_SRC-1:0]   src_ready;
   logic                 out_valid;
   logic [SRC_W-1:0]     out_src;
   logic                 out_match;
   logic                 out_frame_done;
   logic [CNT_W-1:0]     out_count;

   int total = 0;
   int bad   = 0;

   logic [NUM_SRC-1:0] obs_rdy;
   logic               obs_vld;
   logic [SRC_W-1:0]   obs_src;
   logic               obs_m;
   logic               obs_fd;
   logic [CNT_W-1:0]   obs_cnt;

   id_stream_sched #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .src_valid      (src_valid),
      .src_char       (src_char),
      .src_ready      (src_ready),
      .out_valid      (out_valid),
      .out_src        (out_src),
      .out_match      (out_match),
      .out_frame_done (out_frame_done),
      .out_count      (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one character on source s alone for one cycle and capture the result.
   // Called at a falling edge; returns at the next falling edge.
   task automatic send(input int s, input logic [7:0] c);
      src_valid = '0;
      src_char  = '0;
      src_valid[s] = 1'b1;
      src_char[s*8 +: 8] = c;
      #1;
      obs_rdy = src_ready;
      @(posedge clk);
      #1;
      obs_vld = out_valid;
      obs_src = out_src;
      obs_m   = out_match;
      obs_fd  = out_frame_done;
      obs_cnt = out_count;
      src_valid = '0;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      src_valid = '1;
      src_char  = {4{8'h61}};
      #2;
      total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", src_ready); end
      total++; if ({out_valid, out_src, out_match, out_frame_done, out_count} !== 7'd0) begin bad++;
         $display("FAIL reset_outs: got %b want 0", {out_valid, out_src, out_match, out_frame_done, out_count}); end
      src_valid = '0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", out_valid); end
      @(negedge clk);
   endtask

   task automatic test_ab12();
      logic [7:0] str [5] = '{8'h61, 8'h62, 8'h31, 8'h32, 8'h00};
      int         em  [5] = '{0, 0, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         send(0, str[i]);
         total++; if (obs_rdy !== 4'b0001) begin bad++; $display("FAIL ab12_rdy[%0d]: got %b want 0001", i, obs_rdy); end
         total++; if (obs_vld !== 1'b1 || obs_src !== 2'd0) begin bad++; $display("FAIL ab12_src[%0d]: got v%b s%0d want v1 s0", i, obs_vld, obs_src); end
         total++; if (obs_m !== em[i][0]) begin bad++; $display("FAIL ab12_match[%0d]: got %b want %0d", i, obs_m, em[i]); end
         total++; if (obs_fd !== (i == 4)) begin bad++; $display("FAIL ab12_fd[%0d]: got %b want %0d", i, obs_fd, (i == 4)); end
         total++; if (obs_cnt !== ((i == 4) ? 2'd1 : 2'd0)) begin bad++; $display("FAIL ab12_cnt[%0d]: got %0d want %0d", i, obs_cnt, (i == 4)); end
      end
   endtask

   task automatic test_multi_id();
      // "x1 y2z3" NUL: identifiers close at ' ', 'z' and NUL.
      logic [7:0] str [8] = '{8'h78, 8'h31, 8'h20, 8'h79, 8'h32, 8'h7A, 8'h33, 8'h00};
      int         em  [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
      for (int i = 0; i < 8; i++) begin
         send(1, str[i]);
         total++; if (obs_rdy !== 4'b0010 || obs_src !== 2'd1) begin bad++; $display("FAIL multi_src[%0d]: got r%b s%0d want r0010 s1", i, obs_rdy, obs_src); end
         total++; if (obs_m !== em[i][0]) begin bad++; $display("FAIL multi_match[%0d]: got %b want %0d", i, obs_m, em[i]); end
      end
      total++; if (obs_fd !== 1'b1 || obs_cnt !== 2'd3) begin bad++; $display("FAIL multi_count: got fd%b c%0d want fd1 c3", obs_fd, obs_cnt); end
      // Context must be S0 (digit does not match) and count cleared.
      send(1, 8'h35);
      total++; if (obs_m !== 1'b0) begin bad++; $display("FAIL multi_ctx_clear: got %b want 0", obs_m); end
      send(1, 8'h00);
      total++; if (obs_fd !== 1'b1 || obs_cnt !== 2'd0) begin bad++; $display("FAIL multi_cnt_clear: got fd%b c%0d want fd1 c0", obs_fd, obs_cnt); end
   endtask

   task automatic test_round_robin();
      logic [3:0] one = 4'b0001;
      pulse_reset();
      src_valid = '1;
      src_char  = {4{8'h61}};
      for (int k = 0; k < 8; k++) begin
         #1;
         total++; if (src_ready !== (one << (k % 4))) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, src_ready, one << (k % 4)); end
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4)) begin bad++; $display("FAIL rr_src[%0d]: got v%b s%0d want v1 s%0d", k, out_valid, out_src, k % 4); end
         @(negedge clk);
      end
      src_valid = '0;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0 || out_src !== 2'd0) begin bad++; $display("FAIL rr_idle: got v%b s%0d want v0 s0", out_valid, out_src); end
      @(negedge clk);
      pulse_reset();
   endtask

   task automatic test_interleave();
      send(0, 8'h61);
      total++; if (obs_m !== 1'b0) begin bad++; $display("FAIL il_a: got %b want 0", obs_m); end
      send(2, 8'h62);
      send(2, 8'h39);
      total++; if (obs_m !== 1'b1 || obs_src !== 2'd2) begin bad++; $display("FAIL il_b9: got m%b s%0d want m1 s2", obs_m, obs_src); end
      send(0, 8'h37);
      total++; if (obs_m !== 1'b1 || obs_src !== 2'd0) begin bad++; $display("FAIL il_a7: got m%b s%0d want m1 s0", obs_m, obs_src); end
      send(0, 8'h00);
      total++; if (obs_cnt !== 2'd1) begin bad++; $display("FAIL il_cnt0: got %0d want 1", obs_cnt); end
      send(2, 8'h00);
      total++; if (obs_cnt !== 2'd1) begin bad++; $display("FAIL il_cnt2: got %0d want 1", obs_cnt); end
   endtask

   task automatic test_saturation();
      logic [7:0] str [3] = '{8'h61, 8'h31, 8'h20};
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 3; i++) send(0, str[i]);
      end
      total++; if (obs_cnt !== 2'd0) begin bad++; $display("FAIL sat_mid_cnt: got %0d want 0", obs_cnt); end
      send(0, 8'h00);
      total++; if (obs_fd !== 1'b1 || obs_cnt !== 2'd3) begin bad++; $display("FAIL sat_count: got fd%b c%0d want fd1 c3", obs_fd, obs_cnt); end
   endtask

   task automatic test_reset_mid();
      send(3, 8'h61);
      send(3, 8'h31);
      total++; if (obs_m !== 1'b1 || obs_src !== 2'd3) begin bad++; $display("FAIL rm_pre: got m%b s%0d want m1 s3", obs_m, obs_src); end
      reset = 1'b0;
      #1;
      total++; if ({out_valid, out_src, out_match, out_frame_done, out_count} !== 7'd0) begin bad++;
         $display("FAIL rm_async_outs: got %b want 0", {out_valid, out_src, out_match, out_frame_done, out_count}); end
      @(negedge clk);
      reset = 1'b1;
      send(3, 8'h00);
      total++; if (obs_fd !== 1'b1 || obs_cnt !== 2'd0) begin bad++; $display("FAIL rm_nul: got fd%b c%0d want fd1 c0", obs_fd, obs_cnt); end
   endtask

   task automatic test_underscore();
`ifdef IDSCHED_UNDERSCORE_EN
      logic       m_5 = 1'b1;
      logic [1:0] c_n = 2'd1;
`else
      logic       m_5 = 1'b0;
      logic [1:0] c_n = 2'd0;
`endif
      send(0, 8'h5F);
      total++; if (obs_m !== 1'b0) begin bad++; $display("FAIL us_under: got %b want 0", obs_m); end
      send(0, 8'h35);
      total++; if (obs_m !== m_5) begin bad++; $display("FAIL us_digit: got %b want %b", obs_m, m_5); end
      send(0, 8'h00);
      total++; if (obs_cnt !== c_n) begin bad++; $display("FAIL us_count: got %0d want %0d", obs_cnt, c_n); end
   endtask

   initial begin
      reset     = 1'b0;
      src_valid = '0;
      src_char  = '0;
      test_reset();
      test_ab12();
      test_multi_id();
      test_round_robin();
      test_interleave();
      test_saturation();
      test_reset_mid();
      test_underscore();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
